// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues data-cache requests for loads/stores, stalls the
// pipeline until the cache responds, and registers the MEM/WB writeback.
module mem_stage_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en_i,
    input  logic        dREN_i,
    input  logic        dWEN_i,
    input  logic        halt_i,
    input  logic        RegWr_i,
    input  logic        ZeroFlag_i,
    input  logic [4:0]  wsel_i,
    input  logic [2:0]  MemToReg_i,
    input  logic [2:0]  PCsrc_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] branchaddr_i,
    input  logic [31:0] jaddr_i,
    input  logic [31:0] lui_imm_i,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_RegWr,
    output logic        wb_halt,
    output logic [4:0]  wb_wsel,
    output logic [31:0] wb_wdat,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        halted,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;

    logic        l_ren;
    logic        l_wen;
    logic        l_regwr;
    logic [4:0]  l_wsel;
    logic [2:0]  l_m2r;
    logic [31:0] l_addr;
    logic [31:0] l_store;
    logic [31:0] l_pc4;
    logic [31:0] l_lui;

    logic        idle_en;
    logic        in_access;
    logic        mem_op;
    logic        br_taken;
    logic [31:0] br_target;

    function automatic logic [31:0] wdat_sel(
        input logic [2:0]  m2r,
        input logic [31:0] addr,
        input logic [31:0] load,
        input logic [31:0] pc4,
        input logic [31:0] lui
    );
        case (m2r)
            3'd1:    return load;
            3'd2:    return pc4;
            3'd3:    return lui;
            default: return addr;
        endcase
    endfunction

    // Combinational outputs are gated by RST so everything reads 0 during reset.
    assign idle_en   = (state == IDLE) && en_i && !RST;
    assign in_access = (state == ACCESS) && !RST;
    assign mem_op    = dREN_i || dWEN_i;

    assign dmemWEN   = in_access && l_wen;
    assign dmemREN   = in_access && l_ren && !l_wen;
    assign dmemaddr  = in_access ? l_addr : 32'd0;
    assign dmemstore = in_access ? l_store : 32'd0;
    assign mem_stall = (idle_en && !halt_i && mem_op) || (in_access && !dhit);
    assign fsm_state = state;

    always_comb begin
        br_taken  = 1'b0;
        br_target = pc4_i;
        case (PCsrc_i)
            3'd1: begin
                br_taken  = ZeroFlag_i;
                br_target = branchaddr_i;
            end
            3'd2: begin
                br_taken  = !ZeroFlag_i;
                br_target = branchaddr_i;
            end
            3'd3: begin
                br_taken  = 1'b1;
                br_target = jaddr_i;
            end
            default: begin
                br_taken  = 1'b0;
                br_target = pc4_i;
            end
        endcase
        pc_redirect = idle_en && br_taken;
        redirect_pc = RST ? 32'd0 : br_target;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            l_ren    <= 1'b0;
            l_wen    <= 1'b0;
            l_regwr  <= 1'b0;
            l_wsel   <= 5'd0;
            l_m2r    <= 3'd0;
            l_addr   <= 32'd0;
            l_store  <= 32'd0;
            l_pc4    <= 32'd0;
            l_lui    <= 32'd0;
            wb_valid <= 1'b0;
            wb_RegWr <= 1'b0;
            wb_halt  <= 1'b0;
            wb_wsel  <= 5'd0;
            wb_wdat  <= 32'd0;
            halted   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_halt  <= 1'b0;
            wb_RegWr <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i && halt_i) begin
                        state    <= HALTED;
                        halted   <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_halt  <= 1'b1;
                        wb_wsel  <= 5'd0;
                        wb_wdat  <= 32'd0;
                    end else if (en_i && mem_op) begin
                        state   <= ACCESS;
                        l_ren   <= dREN_i && !dWEN_i;
                        l_wen   <= dWEN_i;
                        l_regwr <= RegWr_i;
                        l_wsel  <= wsel_i;
                        l_m2r   <= MemToReg_i;
                        l_addr  <= addr_i;
                        l_store <= store_i;
                        l_pc4   <= pc4_i;
                        l_lui   <= lui_imm_i;
                    end else if (en_i) begin
                        wb_valid <= 1'b1;
                        wb_RegWr <= RegWr_i && (wsel_i != 5'd0);
                        wb_wsel  <= wsel_i;
                        wb_wdat  <= wdat_sel(MemToReg_i, addr_i, dmemload, pc4_i, lui_imm_i);
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_RegWr <= l_regwr && (l_wsel != 5'd0);
                        wb_wsel  <= l_wsel;
                        wb_wdat  <= wdat_sel(l_m2r, l_addr, dmemload, l_pc4, l_lui);
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vectors, writebacks checked from an
// expected queue by an independent monitor, direct checks for stalls/requests.
module tb_mem_stage_ctrl;

    localparam int W = 39;  // {halt, RegWr, wsel[4:0], wdat[31:0]}
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en_i, dREN_i, dWEN_i, halt_i, RegWr_i, ZeroFlag_i;
    logic [4:0]  wsel_i;
    logic [2:0]  MemToReg_i, PCsrc_i;
    logic [31:0] addr_i, store_i, pc4_i, branchaddr_i, jaddr_i, lui_imm_i;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall;
    logic        wb_valid, wb_RegWr, wb_halt;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [1:0]  fsm_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    logic [W-1:0] act_e;
    int n_cmp = 0;
    int n_err = 0;

    mem_stage_ctrl dut (
        .CLK(CLK), .RST(RST), .en_i(en_i), .dREN_i(dREN_i), .dWEN_i(dWEN_i),
        .halt_i(halt_i), .RegWr_i(RegWr_i), .ZeroFlag_i(ZeroFlag_i),
        .wsel_i(wsel_i), .MemToReg_i(MemToReg_i), .PCsrc_i(PCsrc_i),
        .addr_i(addr_i), .store_i(store_i), .pc4_i(pc4_i),
        .branchaddr_i(branchaddr_i), .jaddr_i(jaddr_i), .lui_imm_i(lui_imm_i),
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_RegWr(wb_RegWr), .wb_halt(wb_halt),
        .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .halted(halted), .fsm_state(fsm_state)
    );

    // Clock / timeout
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, required end");
        $fatal(1, "timeout");
    end

    // Monitor: every wb_valid cycle must match the oldest expected writeback
    always @(negedge CLK) begin
        if (wb_valid === 1'b1) begin
            act_e = {wb_halt, wb_RegWr, wb_wsel, wb_wdat};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got %h, required no writeback", act_e);
            end else begin
                exp_e = exp_q.pop_front();
                if (act_e !== exp_e) begin
                    n_err++;
                    $display("FAIL wb_data: got %h, required %h", act_e, exp_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        en_i = 0; dREN_i = 0; dWEN_i = 0; halt_i = 0; RegWr_i = 0; ZeroFlag_i = 0;
        wsel_i = 0; MemToReg_i = 0; PCsrc_i = 0;
        addr_i = 0; store_i = 0; pc4_i = 0; branchaddr_i = 0; jaddr_i = 0; lui_imm_i = 0;
        dhit = 0; dmemload = 0;
    endtask

    // Non-memory instruction: one-cycle writeback, no stall
    task automatic alu_op(input logic regwr, input logic [4:0] wsel, input logic [2:0] m2r,
                          input logic [31:0] addr, input logic [31:0] exp_wdat);
        en_i = 1; RegWr_i = regwr; wsel_i = wsel; MemToReg_i = m2r; addr_i = addr;
        pc4_i = 32'h0000_1004; lui_imm_i = 32'hABCD_0000; dmemload = 32'h5555_5555;
        exp_q.push_back({1'b0, regwr && (wsel != 5'd0), wsel, exp_wdat});
        @(negedge CLK);
        check("alu_stall", mem_stall, 0);
        tick();
        clear_inputs();
        @(negedge CLK);
        check("alu_latency", wb_valid, 1);
        tick();
    endtask

    // Load/store: cache answers after 'waits' miss cycles in ACCESS
    task automatic mem_op(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] store, input logic [2:0] m2r, input logic [4:0] wsel,
                          input logic regwr, input int waits, input logic [31:0] load,
                          input logic [31:0] exp_wdat);
        int stall_cnt;
        int req_cnt;
        en_i = 1; dREN_i = ren; dWEN_i = wen; addr_i = addr; store_i = store;
        MemToReg_i = m2r; wsel_i = wsel; RegWr_i = regwr;
        exp_q.push_back({1'b0, regwr && (wsel != 5'd0), wsel, exp_wdat});
        @(negedge CLK);
        check("mem_issue_stall", mem_stall, 1);
        check("mem_issue_req", {dmemREN, dmemWEN}, 0);
        stall_cnt = 1;
        req_cnt = 0;
        tick();
        // Garbage on the inputs during ACCESS must be ignored
        en_i = 1; dREN_i = 1; dWEN_i = 0; halt_i = 1; PCsrc_i = 3'd3;
        addr_i = 32'hFFFF_FFFF; store_i = 32'hFFFF_FFFF; wsel_i = 5'd31;
        for (int i = 0; i <= waits; i++) begin
            dhit = (i == waits);
            dmemload = dhit ? load : 32'hBAD0_BAD0;
            @(negedge CLK);
            if (mem_stall) stall_cnt++;
            if (wen ? dmemWEN : dmemREN) req_cnt++;
            check("mem_wrong_req", wen ? dmemREN : dmemWEN, 0);
            check("mem_addr", dmemaddr, addr);
            check("mem_store", dmemstore, store);
            check("mem_no_redirect", pc_redirect, 0);
            tick();
        end
        clear_inputs();
        check("mem_stall_cycles", 32'(stall_cnt), 32'(waits + 1));
        check("mem_req_cycles", 32'(req_cnt), 32'(waits + 1));
        @(negedge CLK);
        check("mem_req_drop", {dmemREN, dmemWEN}, 0);
        check("mem_back_idle", fsm_state, S_IDLE);
        tick();
    endtask

    task automatic branch(input logic [2:0] pcsrc, input logic zero, input logic exp_taken,
                          input logic [31:0] exp_pc);
        en_i = 1; PCsrc_i = pcsrc; ZeroFlag_i = zero;
        branchaddr_i = 32'h0000_4000; jaddr_i = 32'h0000_8000; pc4_i = 32'h0000_1004;
        addr_i = 32'h77;
        exp_q.push_back({1'b0, 1'b0, 5'd0, 32'h77});
        @(negedge CLK);
        check("br_taken", pc_redirect, exp_taken);
        if (exp_taken || pcsrc == 3'd0) check("br_target", redirect_pc, exp_pc);
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        // Drive busy inputs during reset; outputs must still read 0
        en_i = 1; dREN_i = 1; PCsrc_i = 3'd3; jaddr_i = 32'h1234_5678;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", mem_stall, 0);
        check("rst_req", {dmemREN, dmemWEN}, 0);
        check("rst_wb", {wb_valid, wb_RegWr, wb_halt}, 0);
        check("rst_wb_data", wb_wdat, 0);
        check("rst_halted", halted, 0);
        check("rst_redirect", pc_redirect, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_state", fsm_state, S_IDLE);
        tick();
        RST = 0;
        clear_inputs();
        tick();

        alu_op(1'b1, 5'd0,  3'd0, 32'd5,         32'd5);
        alu_op(1'b1, 5'd4,  3'd2, 32'h10,        32'h0000_1004);
        alu_op(1'b1, 5'd31, 3'd3, 32'h20,        32'hABCD_0000);
        alu_op(1'b1, 5'd7,  3'd6, 32'h99,        32'h99);

        mem_op(1'b1, 1'b0, 32'h100, 32'h0,    3'd1, 5'd8, 1'b1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        mem_op(1'b0, 1'b1, 32'h200, 32'h1234, 3'd0, 5'd5, 1'b0, 0, 32'h0,         32'h200);
        mem_op(1'b1, 1'b1, 32'h300, 32'hCAFE, 3'd0, 5'd6, 1'b1, 1, 32'h0,         32'h300);

        branch(3'd1, 1'b1, 1'b1, 32'h0000_4000);
        branch(3'd1, 1'b0, 1'b0, 32'h0);
        branch(3'd2, 1'b0, 1'b1, 32'h0000_4000);
        branch(3'd2, 1'b1, 1'b0, 32'h0);
        branch(3'd3, 1'b0, 1'b1, 32'h0000_8000);
        branch(3'd0, 1'b1, 1'b0, 32'h0000_1004);

        // Reset in the middle of a pending load
        en_i = 1; dREN_i = 1; addr_i = 32'h500; wsel_i = 5'd9; RegWr_i = 1; MemToReg_i = 3'd1;
        @(negedge CLK);
        tick();
        clear_inputs();
        @(negedge CLK);
        check("rstmid_req_before", dmemREN, 1);
        tick();
        RST = 1; dhit = 1; dmemload = 32'h1111_1111;
        tick();
        RST = 0; dhit = 0;
        @(negedge CLK);
        check("rstmid_req_after", {dmemREN, dmemWEN}, 0);
        check("rstmid_stall", mem_stall, 0);
        check("rstmid_wb", wb_valid, 0);
        check("rstmid_state", fsm_state, S_IDLE);
        tick();
        @(negedge CLK);
        check("rstmid_wb_later", wb_valid, 0);
        tick();

        // Halt wins over a load and is sticky until reset
        en_i = 1; halt_i = 1; dREN_i = 1; addr_i = 32'h300; wsel_i = 5'd3; RegWr_i = 1;
        exp_q.push_back({1'b1, 1'b0, 5'd0, 32'd0});
        @(negedge CLK);
        check("halt_no_req", dmemREN, 0);
        check("halt_no_stall", mem_stall, 0);
        tick();
        halt_i = 0;
        @(negedge CLK);
        check("halt_flag", halted, 1);
        check("halt_state", fsm_state, S_HALTED);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge CLK);
            check("halt_sticky", halted, 1);
            check("halt_quiet_req", {dmemREN, dmemWEN}, 0);
            check("halt_quiet_stall", mem_stall, 0);
            check("halt_quiet_wb", {wb_valid, wb_halt}, 0);
        end
        tick();
        RST = 1;
        tick();
        RST = 0;
        clear_inputs();
        @(negedge CLK);
        check("halt_cleared", halted, 0);
        check("halt_cleared_state", fsm_state, S_IDLE);
        tick();
        tick();

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
